// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester handshakes and the single-port RAM bus
// around ram_port_arbiter. The slave modport is the arbiter's view.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
);
  logic                  req0_valid;
  logic                  req0_rw;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_data;

  logic                  req1_valid;
  logic                  req1_rw;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_ready;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_data;

  logic                  ram_rw;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_datain;
  logic [DATA_WIDTH-1:0] ram_dataout;

  modport slave (
    input  req0_valid, req0_rw, req0_addr, req0_wdata,
    input  req1_valid, req1_rw, req1_addr, req1_wdata,
    input  ram_dataout,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output ram_rw, ram_addr, ram_datain
  );

  modport master (
    output req0_valid, req0_rw, req0_addr, req0_wdata,
    output req1_valid, req1_rw, req1_addr, req1_wdata,
    output ram_dataout,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  ram_rw, ram_addr, ram_datain
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port synchronous RAM
// between two requesters; one command in flight, 3 cycles per transaction.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic                  cmd_id_p1;
  logic                  grant0;
  logic                  grant1;
  logic                  win_rw;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // Ties go to whichever requester was not served last.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (state == IDLE && !rst) begin
      if (bus.req0_valid && (!bus.req1_valid || last_grant))
        grant0 = 1'b1;
      else if (bus.req1_valid)
        grant1 = 1'b1;
    end
    win_rw    = grant1 ? bus.req1_rw    : bus.req0_rw;
    win_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
    win_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      cmd_id_p1      <= 1'b0;
      bus.ram_rw     <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_datain <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp0_data  <= '0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp1_data  <= '0;
    end else begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      case (state)
        // p0: the accepted command goes straight onto the RAM port registers
        IDLE: begin
          if (grant0 || grant1) begin
            cmd_id_p1      <= grant1;
            last_grant     <= grant1;
            bus.ram_rw     <= win_rw;
            bus.ram_addr   <= win_addr;
            bus.ram_datain <= win_wdata;
            state          <= ISSUE;
          end
        end
        // p1: RAM samples at this edge; addr/datain keep their last values
        ISSUE: begin
          bus.ram_rw <= 1'b0;
          state      <= CAPTURE;
        end
        // p2: RAM output (read data or write echo) returns to the issuer
        CAPTURE: begin
          if (cmd_id_p1) begin
            bus.rsp1_valid <= 1'b1;
            bus.rsp1_data  <= bus.ram_dataout;
          end else begin
            bus.rsp0_valid <= 1'b1;
            bus.rsp0_data  <= bus.ram_dataout;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: table of single transactions plus
// hand-written sequences for ties, back-to-back, reset and dropped requests.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] mem [16];
  logic [3:0] last_d [2];

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) bus ();

  ram_port_arbiter #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: registered output, echoes datain on a write
  initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;
  always @(posedge clk) begin
    if (bus.ram_rw) begin
      mem[bus.ram_addr] <= bus.ram_datain;
      bus.ram_dataout   <= bus.ram_datain;
    end else begin
      bus.ram_dataout   <= mem[bus.ram_addr];
    end
  end

  typedef struct {
    int         id;
    logic       rw;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 1) ? bus.req1_ready : bus.req0_ready;
  endfunction
  function automatic logic rspv(input int id);
    return (id == 1) ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction
  function automatic logic [3:0] rspd(input int id);
    return (id == 1) ? bus.rsp1_data : bus.rsp0_data;
  endfunction

  task automatic set_req(input int id, input logic v, input logic rw,
                         input logic [3:0] a, input logic [3:0] d);
    if (id == 1) begin
      bus.req1_valid = v; bus.req1_rw = rw; bus.req1_addr = a; bus.req1_wdata = d;
    end else begin
      bus.req0_valid = v; bus.req0_rw = rw; bus.req0_addr = a; bus.req0_wdata = d;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    last_d[0] = 4'h0;
    last_d[1] = 4'h0;
  endtask

  task automatic do_txn(input vec_t t);
    int n;
    int o;
    o = 1 - t.id;
    @(posedge clk); #1 set_req(t.id, 1'b1, t.rw, t.addr, t.wdata);
    n = 0;
    @(negedge clk);
    while (!rdy(t.id) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("ready", rdy(t.id), 1'b1);
    chk("ready_same_cycle", n[3:0], 4'h0);
    chk("ready_other_low", rdy(o), 1'b0);
    @(posedge clk); #1 set_req(t.id, 1'b0, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    chk("issue_rw", bus.ram_rw, t.rw);
    chk("issue_addr", bus.ram_addr, t.addr);
    if (t.rw) chk("issue_datain", bus.ram_datain, t.wdata);
    chk("ready_busy", rdy(t.id), 1'b0);
    @(negedge clk);
    chk("capture_rw", bus.ram_rw, 1'b0);
    chk("rsp_early", rspv(t.id), 1'b0);
    @(negedge clk);
    chk("rsp_valid", rspv(t.id), 1'b1);
    chk("rsp_data", rspd(t.id), t.exp);
    chk("rsp_other_valid", rspv(o), 1'b0);
    chk("rsp_other_hold", rspd(o), last_d[o]);
    last_d[t.id] = t.exp;
    @(negedge clk);
    chk("rsp_pulse", rspv(t.id), 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 1'b0, 4'd5,  4'h0, 4'h0};
    vecs[1] = '{0, 1'b1, 4'd3,  4'hA, 4'hA};
    vecs[2] = '{1, 1'b0, 4'd3,  4'h0, 4'hA};
    vecs[3] = '{1, 1'b1, 4'd15, 4'h6, 4'h6};
    vecs[4] = '{0, 1'b0, 4'd15, 4'h0, 4'h6};
    vecs[5] = '{0, 1'b1, 4'd0,  4'h5, 4'h5};
    vecs[6] = '{1, 1'b0, 4'd0,  4'h0, 4'h5};
    vecs[7] = '{0, 1'b0, 4'd3,  4'h0, 4'hA};

    set_req(0, 1'b1, 1'b1, 4'd7, 4'h3);
    set_req(1, 1'b0, 1'b0, 4'd0, 4'h0);
    last_d[0] = 4'h0;
    last_d[1] = 4'h0;

    // Reset state, with a request pending while rst is high
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_ram_rw", bus.ram_rw, 1'b0);
    chk("rst_ram_addr", bus.ram_addr, 4'h0);
    chk("rst_ram_datain", bus.ram_datain, 4'h0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
    chk("rst_rsp0_data", bus.rsp0_data, 4'h0);
    chk("rst_rsp1_data", bus.rsp1_data, 4'h0);
    @(posedge clk); #1 rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 4'd0, 4'h0);

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // Both requesters valid for 12 cycles: grants alternate every 3 cycles
    do_reset();
    set_req(0, 1'b1, 1'b0, 4'd5, 4'h0);
    set_req(1, 1'b1, 1'b0, 4'd3, 4'h0);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      chk("tie_ready0", bus.req0_ready, (c == 0 || c == 6));
      chk("tie_ready1", bus.req1_ready, (c == 3 || c == 9));
      chk("tie_rsp0_valid", bus.rsp0_valid, (c == 3 || c == 9));
      chk("tie_rsp1_valid", bus.rsp1_valid, (c == 6 || c == 12));
      if (c == 6) chk("tie_rsp1_data", bus.rsp1_data, 4'hA);
      @(posedge clk); #1;
      if (c == 11) begin
        set_req(0, 1'b0, 1'b0, 4'd0, 4'h0);
        set_req(1, 1'b0, 1'b0, 4'd0, 4'h0);
      end
    end

    // Requester 1 alone: write 15 then read 15, accepted back to back
    set_req(1, 1'b1, 1'b1, 4'd15, 4'hF);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("b2b_ready1", bus.req1_ready, (c == 0 || c == 3));
      chk("b2b_rsp1_valid", bus.rsp1_valid, (c == 3 || c == 6));
      chk("b2b_rsp0_valid", bus.rsp0_valid, 1'b0);
      if (c == 3 || c == 6) chk("b2b_rsp1_data", bus.rsp1_data, 4'hF);
      @(posedge clk); #1;
      if (c == 0) set_req(1, 1'b1, 1'b0, 4'd15, 4'hF);
      if (c == 3) set_req(1, 1'b0, 1'b0, 4'd0, 4'h0);
    end

    // Reset during CAPTURE of a req0 read drops the response
    set_req(0, 1'b1, 1'b0, 4'd3, 4'h0);
    @(negedge clk);
    chk("rc_ready0", bus.req0_ready, 1'b1);
    @(posedge clk); #1 set_req(0, 1'b0, 1'b0, 4'd0, 4'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rc_rsp0_valid", bus.rsp0_valid, 1'b0);
    chk("rc_rsp1_data", bus.rsp1_data, 4'h0);
    chk("rc_ram_addr", bus.ram_addr, 4'h0);
    chk("rc_ram_datain", bus.ram_datain, 4'h0);
    chk("rc_ram_rw", bus.ram_rw, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rc_no_rsp0", bus.rsp0_valid, 1'b0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 4'd3, 4'h0);
    set_req(1, 1'b1, 1'b0, 4'd3, 4'h0);
    @(negedge clk);
    chk("rc_tie_ready0", bus.req0_ready, 1'b1);
    chk("rc_tie_ready1", bus.req1_ready, 1'b0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 4'd0, 4'h0);
    set_req(1, 1'b0, 1'b0, 4'd0, 4'h0);
    repeat (3) @(posedge clk);
    last_d[0] = 4'hA;
    last_d[1] = 4'h0;

    // req0 raised then dropped while req1 is being served
    #1 set_req(1, 1'b1, 1'b1, 4'd9, 4'h6);
    @(negedge clk);
    chk("drop_ready1", bus.req1_ready, 1'b1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 4'd0, 4'h0);
    set_req(0, 1'b1, 1'b0, 4'd4, 4'h0);
    @(negedge clk);
    chk("drop_ready0_issue", bus.req0_ready, 1'b0);
    @(posedge clk); #1 set_req(0, 1'b0, 1'b0, 4'd0, 4'h0);
    @(negedge clk);
    chk("drop_ready0_capture", bus.req0_ready, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("drop_ram_rw", bus.ram_rw, 1'b0);
      chk("drop_ram_addr", bus.ram_addr, 4'd9);
      chk("drop_rsp0_valid", bus.rsp0_valid, 1'b0);
    end
    last_d[1] = 4'h6;

    // A write in ISSUE when rst rises still lands in the RAM
    @(posedge clk); #1 set_req(0, 1'b1, 1'b1, 4'd2, 4'hC);
    @(negedge clk);
    chk("rw_ready0", bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 4'd0, 4'h0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    last_d[0] = 4'h0;
    last_d[1] = 4'h0;
    do_txn('{1, 1'b0, 4'd2, 4'h0, 4'hC});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
